// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array: default operand/accumulator widths and the
// arithmetic-mode selectors used by both the PE and the array top.
package systolic_pkg;

  localparam int unsigned AccGuardBits = 4;

  // Accumulator width: a full-precision product plus guard bits for tile growth.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned guard);
    return 2 * dw + guard;
  endfunction

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultAccWidth  = acc_width(DefaultDataWidth, AccGuardBits);

  localparam bit ModeUnsigned = 1'b0;
  localparam bit ModeSigned   = 1'b1;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate for one PE: operand extension, product and tile add.
// With SYSTOLIC_PE_SAT_EN the add clamps to the accumulator range and flags saturation.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefaultDataWidth,
  parameter int unsigned ACCWIDTH  = acc_width(DATAWIDTH, AccGuardBits),
  parameter bit          SIGNED    = ModeUnsigned
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic                 first_i,
  input  logic [ACCWIDTH-1:0]  acc_i,
`ifdef SYSTOLIC_PE_SAT_EN
  output logic                 sat_o,
`endif
  output logic [ACCWIDTH-1:0]  acc_next_o
);

  localparam int unsigned ProdWidth = 2 * DATAWIDTH;

  logic [ProdWidth-1:0] a_ext;
  logic [ProdWidth-1:0] b_ext;
  logic [ProdWidth-1:0] prod;
  logic [ACCWIDTH-1:0]  prod_ext;
  logic [ACCWIDTH-1:0]  base;

  always_comb begin
    if (SIGNED) begin
      a_ext = {{DATAWIDTH{a_i[DATAWIDTH-1]}}, a_i};
      b_ext = {{DATAWIDTH{b_i[DATAWIDTH-1]}}, b_i};
    end else begin
      a_ext = {{DATAWIDTH{1'b0}}, a_i};
      b_ext = {{DATAWIDTH{1'b0}}, b_i};
    end
    // The low 2*DW bits of the extended product are exact in both modes.
    prod = a_ext * b_ext;
    if (SIGNED) begin
      prod_ext = ACCWIDTH'($signed(prod));
    end else begin
      prod_ext = ACCWIDTH'(prod);
    end
    base = first_i ? '0 : acc_i;
  end

`ifdef SYSTOLIC_PE_SAT_EN
  logic [ACCWIDTH:0] sum_wide;
  logic              over;

  always_comb begin
    sum_wide = {1'b0, base} + {1'b0, prod_ext};
    if (SIGNED) begin
      // Signed overflow: like-signed operands producing a result of the other sign.
      over = (base[ACCWIDTH-1] == prod_ext[ACCWIDTH-1]) &&
             (sum_wide[ACCWIDTH-1] != base[ACCWIDTH-1]);
    end else begin
      over = sum_wide[ACCWIDTH];
    end
    sat_o = over;
    if (!over) begin
      acc_next_o = sum_wide[ACCWIDTH-1:0];
    end else if (!SIGNED) begin
      acc_next_o = '1;
    end else if (base[ACCWIDTH-1]) begin
      acc_next_o = {1'b1, {(ACCWIDTH-1){1'b0}}};
    end else begin
      acc_next_o = {1'b0, {(ACCWIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_next_o = base + prod_ext;
`endif

endmodule

// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: forwards A east / B south, accumulates tiles, drains results.
// Define SYSTOLIC_PE_SAT_EN for saturating accumulation and the sticky ovf output.
module systolic_pe_acc
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefaultDataWidth,
  parameter int unsigned ACCWIDTH  = acc_width(DATAWIDTH, AccGuardBits),
  parameter bit          SIGNED    = ModeUnsigned
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [DATAWIDTH-1:0] a_in,
  input  logic [DATAWIDTH-1:0] b_in,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic [DATAWIDTH-1:0] a_out,
  output logic [DATAWIDTH-1:0] b_out,
  output logic                 valid_out,
  output logic                 first_out,
  output logic                 last_out,
  output logic [ACCWIDTH-1:0]  result,
  output logic                 result_valid,
  input  logic                 res_load,
  input  logic                 res_shift,
  input  logic [ACCWIDTH-1:0]  chain_in,
`ifdef SYSTOLIC_PE_SAT_EN
  output logic                 ovf,
`endif
  output logic [ACCWIDTH-1:0]  chain_out
);

  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic                 valid_q;
  logic                 first_q;
  logic                 last_q;
  logic [ACCWIDTH-1:0]  acc_q, acc_d;
  logic [ACCWIDTH-1:0]  result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic [ACCWIDTH-1:0]  chain_q, chain_d;
  logic [ACCWIDTH-1:0]  acc_next;
  logic                 capture;
`ifdef SYSTOLIC_PE_SAT_EN
  logic                 sat;
  logic                 ovf_q, ovf_d;
`endif

  pe_mac #(
    .DATAWIDTH(DATAWIDTH),
    .ACCWIDTH (ACCWIDTH),
    .SIGNED   (SIGNED)
  ) u_mac (
    .a_i       (a_in),
    .b_i       (b_in),
    .first_i   (in_first),
    .acc_i     (acc_q),
`ifdef SYSTOLIC_PE_SAT_EN
    .sat_o     (sat),
`endif
    .acc_next_o(acc_next)
  );

  assign capture = in_valid & in_last;

  always_comb begin
    acc_d          = in_valid ? acc_next : acc_q;
    result_d       = capture ? acc_next : result_q;
    result_valid_d = capture;
    // Load samples result_q, so a same-cycle capture drains the previous tile's sum.
    if (res_load) begin
      chain_d = result_q;
    end else if (res_shift) begin
      chain_d = chain_in;
    end else begin
      chain_d = chain_q;
    end
`ifdef SYSTOLIC_PE_SAT_EN
    // A new tile clears the flag, but its own first add may set it again.
    ovf_d = ((in_valid && in_first) ? 1'b0 : ovf_q) | (in_valid & sat);
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_q            <= '0;
      b_q            <= '0;
      valid_q        <= 1'b0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      chain_q        <= '0;
`ifdef SYSTOLIC_PE_SAT_EN
      ovf_q          <= 1'b0;
`endif
    end else begin
      a_q            <= a_in;
      b_q            <= b_in;
      valid_q        <= in_valid;
      first_q        <= in_first;
      last_q         <= in_last;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      chain_q        <= chain_d;
`ifdef SYSTOLIC_PE_SAT_EN
      ovf_q          <= ovf_d;
`endif
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign valid_out    = valid_q;
  assign first_out    = first_q;
  assign last_out     = last_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign chain_out    = chain_q;
`ifdef SYSTOLIC_PE_SAT_EN
  assign ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Scoreboard bench: an unsigned and a signed PE share one stimulus stream against an arithmetic
// reference model; a three-PE column exercises the drain chain.
module tb_systolic_pe_acc;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 20;
  localparam int unsigned NCol = 3;
  localparam longint      Full = longint'(1) << AW;
  localparam longint      Mask = Full - 1;
  localparam longint      Half = longint'(1) << (AW - 1);
`ifdef SYSTOLIC_PE_SAT_EN
  localparam longint      Exp17 = 1048575;
`else
  localparam longint      Exp17 = 56849;
`endif

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  logic [DW-1:0] a_in, b_in;
  logic          in_valid, in_first, in_last, res_load, res_shift;
  logic [AW-1:0] chain_in;

  logic [DW-1:0] a_out [2];
  logic [DW-1:0] b_out [2];
  logic          valid_out [2];
  logic          first_out [2];
  logic          last_out [2];
  logic [AW-1:0] result [2];
  logic          result_valid [2];
  logic [AW-1:0] chain_out [2];
`ifdef SYSTOLIC_PE_SAT_EN
  logic          ovf [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    systolic_pe_acc #(.DATAWIDTH(DW), .ACCWIDTH(AW), .SIGNED(g == 1)) u_dut (
      .CLK(CLK), .RSTn(RSTn), .a_in(a_in), .b_in(b_in),
      .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .a_out(a_out[g]), .b_out(b_out[g]), .valid_out(valid_out[g]),
      .first_out(first_out[g]), .last_out(last_out[g]),
      .result(result[g]), .result_valid(result_valid[g]),
      .res_load(res_load), .res_shift(res_shift), .chain_in(chain_in),
`ifdef SYSTOLIC_PE_SAT_EN
      .ovf(ovf[g]),
`endif
      .chain_out(chain_out[g])
    );
  end

  // Drain column, top PE index 0.
  logic [DW-1:0] col_a [NCol];
  logic [DW-1:0] col_b;
  logic          col_v, col_f, col_l, col_load, col_shift;
  logic [AW-1:0] col_top;
  logic [AW-1:0] col_chain [NCol+1];
  logic [DW-1:0] col_a_out [NCol];
  logic [DW-1:0] col_b_out [NCol];
  logic          col_vo [NCol];
  logic          col_fo [NCol];
  logic          col_lo [NCol];
  logic [AW-1:0] col_res [NCol];
  logic          col_rv [NCol];
`ifdef SYSTOLIC_PE_SAT_EN
  logic          col_ovf [NCol];
`endif
  assign col_chain[0] = col_top;

  for (genvar i = 0; i < NCol; i++) begin : g_col
    systolic_pe_acc #(.DATAWIDTH(DW), .ACCWIDTH(AW), .SIGNED(1'b0)) u_pe (
      .CLK(CLK), .RSTn(RSTn), .a_in(col_a[i]), .b_in(col_b),
      .in_valid(col_v), .in_first(col_f), .in_last(col_l),
      .a_out(col_a_out[i]), .b_out(col_b_out[i]), .valid_out(col_vo[i]),
      .first_out(col_fo[i]), .last_out(col_lo[i]),
      .result(col_res[i]), .result_valid(col_rv[i]),
      .res_load(col_load), .res_shift(col_shift), .chain_in(col_chain[i]),
`ifdef SYSTOLIC_PE_SAT_EN
      .ovf(col_ovf[i]),
`endif
      .chain_out(col_chain[i+1])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tile sums from plain integer arithmetic on the accepted pairs.
  typedef struct {int inst; longint val; int cyc;} exp_t;
  exp_t exp_q[$];

  longint        m_acc [2];
  longint        m_res [2];
  longint        m_chain [2];
  bit            m_ovf [2];
  logic [DW-1:0] m_a, m_b;
  logic          m_v, m_f, m_l;

  function automatic longint operand(input int g, input logic [DW-1:0] v);
    return (g == 1) ? longint'($signed(v)) : longint'(v);
  endfunction

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RSTn) begin
      for (int g = 0; g < 2; g++) begin
        m_acc[g] = 0; m_res[g] = 0; m_chain[g] = 0; m_ovf[g] = 0;
      end
      m_a = '0; m_b = '0; m_v = 0; m_f = 0; m_l = 0;
      exp_q.delete();
    end else begin
      m_a = a_in; m_b = b_in; m_v = in_valid; m_f = in_first; m_l = in_last;
      for (int g = 0; g < 2; g++) begin
        longint sum, lo, hi;
        bit clip;
        if (res_load) m_chain[g] = m_res[g];
        else if (res_shift) m_chain[g] = longint'(chain_in);
        if (in_valid) begin
          sum  = (in_first ? 0 : m_acc[g]) + operand(g, a_in) * operand(g, b_in);
          clip = 0;
`ifdef SYSTOLIC_PE_SAT_EN
          lo = (g == 1) ? -Half : 0;
          hi = (g == 1) ? Half - 1 : Full - 1;
          if (sum > hi) begin sum = hi; clip = 1; end
          if (sum < lo) begin sum = lo; clip = 1; end
`else
          lo = 0; hi = 0;
          sum = sum & Mask;
          if (g == 1 && sum >= Half) sum = sum - Full;
`endif
          if (in_first) m_ovf[g] = 0;
          if (clip) m_ovf[g] = 1;
          m_acc[g] = sum;
          if (in_last) begin
            m_res[g] = sum & Mask;
            exp_q.push_back('{g, sum & Mask, cyc});
          end
        end
      end
    end
  end

  // Monitor: compares every output against the model, popping expected tile results on pulses.
  always @(negedge CLK) begin
    int idx;
    if (RSTn) begin
      for (int g = 0; g < 2; g++) begin
        check("a_out", a_out[g], m_a);
        check("b_out", b_out[g], m_b);
        check("valid_out", valid_out[g], m_v);
        check("first_out", first_out[g], m_f);
        check("last_out", last_out[g], m_l);
        check("chain_out", chain_out[g], m_chain[g]);
        check("result_hold", result[g], m_res[g]);
`ifdef SYSTOLIC_PE_SAT_EN
        check("ovf", ovf[g], m_ovf[g]);
`endif
        if (result_valid[g]) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].inst == g && idx < 0) idx = i;
          if (idx < 0) begin
            check("result_valid_spurious", result_valid[g], 1'b0);
          end else begin
            check("result", result[g], exp_q[idx].val);
            check("result_latency", cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
          end
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          check("result_valid_missed", result_valid[exp_q[i].inst], 1'b1);
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic v, input logic f, input logic l);
    step();
    a_in = a; b_in = b; in_valid = v; in_first = f; in_last = l;
  endtask

  task automatic check_all_zero();
    for (int g = 0; g < 2; g++) begin
      check("rst_a_out", a_out[g], 0);
      check("rst_b_out", b_out[g], 0);
      check("rst_flags", {valid_out[g], first_out[g], last_out[g], result_valid[g]}, 0);
      check("rst_result", result[g], 0);
      check("rst_chain", chain_out[g], 0);
`ifdef SYSTOLIC_PE_SAT_EN
      check("rst_ovf", ovf[g], 0);
`endif
    end
    for (int i = 0; i < NCol; i++) begin
      check("rst_col_out", {col_a_out[i], col_b_out[i], col_vo[i], col_fo[i], col_lo[i],
                            col_rv[i]}, 0);
      check("rst_col_res", col_res[i], 0);
      check("rst_col_chain", col_chain[i+1], 0);
`ifdef SYSTOLIC_PE_SAT_EN
      check("rst_col_ovf", col_ovf[i], 0);
`endif
    end
  endtask

  initial begin
    bit in_tile;
    RSTn = 0;
    a_in = '0; b_in = '0; in_valid = 0; in_first = 0; in_last = 0;
    res_load = 0; res_shift = 0; chain_in = '0;
    col_b = 8'd1; col_v = 0; col_f = 0; col_l = 0; col_load = 0; col_shift = 0; col_top = '0;
    for (int i = 0; i < NCol; i++) col_a[i] = '0;

    // Reset with toggling inputs.
    repeat (4) begin
      step();
      a_in = DW'($urandom); b_in = DW'($urandom); in_valid = 1'($urandom);
      in_first = 1'($urandom); in_last = 1'($urandom); res_load = 1'($urandom);
      res_shift = 1'($urandom); chain_in = AW'($urandom);
      col_v = 1'($urandom); col_f = 1'($urandom); col_l = 1'($urandom);
      col_load = 1'($urandom); col_a[0] = DW'($urandom);
      @(negedge CLK);
      check_all_zero();
    end
    step();
    RSTn = 1; a_in = 8'h5A; in_valid = 0; in_first = 0; in_last = 0;
    res_load = 0; res_shift = 0; chain_in = '0;
    col_v = 0; col_f = 0; col_l = 0; col_load = 0; col_a[0] = '0;
    step();
    @(negedge CLK);
    check("fwd_after_reset", a_out[0], 8'h5A);

    // Unsigned tile then back-to-back tile.
    pair(3, 4, 1, 1, 0);
    pair(5, 6, 1, 0, 0);
    pair(7, 8, 1, 0, 1);
    pair(1, 1, 1, 1, 0);
    @(negedge CLK);
    check("tile98", result[0], 98);
    check("tile98_valid", result_valid[0], 1);
    pair(2, 2, 1, 0, 1);
    @(negedge CLK);
    check("tile98_pulse_end", result_valid[0], 0);
    pair(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("tile5", result[0], 5);
    check("tile5_valid", result_valid[0], 1);
    // Idle cycle with junk first/last inside a tile.
    pair(4, 4, 1, 1, 0);
    pair(9, 9, 0, 1, 1);
    pair(1, 3, 1, 0, 1);
    pair(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("tile19_idle", result[0], 19);
    check("tile19_signed", result[1], 19);

    // Signed operands.
    pair(8'hFD, 8'd4, 1, 1, 0);
    pair(8'd2, 8'hFB, 1, 0, 1);
    pair(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("signed_m22", result[1], 20'hFFFEA);
    check("unsigned_same", result[0], 1514);

    // 17 x (255,255).
    pair(255, 255, 1, 1, 0);
    repeat (15) pair(255, 255, 1, 0, 0);
    pair(255, 255, 1, 0, 1);
    pair(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("max17", result[0], Exp17);
    check("max17_signed", result[1], 17);
`ifdef SYSTOLIC_PE_SAT_EN
    check("max17_ovf", ovf[0], 1);
`endif
    pair(1, 1, 1, 1, 1);
    pair(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("single_pair", result[0], 1);
`ifdef SYSTOLIC_PE_SAT_EN
    check("ovf_cleared", ovf[0], 0);
`endif

    // Reset mid-tile after the partial sum has saturated.
    pair(255, 255, 1, 1, 0);
    repeat (17) pair(255, 255, 1, 0, 0);
    step();
    in_valid = 0;
    #2 RSTn = 0;
    #1 check_all_zero();
    step();
    RSTn = 1;

    // Randomized tiles with random drain traffic.
    in_tile = 0;
    repeat (400) begin
      step();
      a_in = DW'($urandom); b_in = DW'($urandom); chain_in = AW'($urandom);
      res_load = ($urandom_range(0, 3) == 0); res_shift = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 0; in_first = 1'($urandom); in_last = 1'($urandom);
      end else begin
        in_valid = 1; in_first = !in_tile || ($urandom_range(0, 15) == 0);
        in_last = ($urandom_range(0, 3) == 0); in_tile = !in_last;
      end
    end
    step();
    in_valid = 0; res_load = 0; res_shift = 0;

    // Drain column holding 10, 20, 30.
    col_a[0] = 10; col_a[1] = 20; col_a[2] = 30; col_v = 1; col_f = 1; col_l = 1;
    step();
    col_v = 0; col_f = 0; col_l = 0;
    step();
    col_load = 1;
    step();
    col_load = 0; col_shift = 1;
    @(negedge CLK);
    check("drain_load", col_chain[NCol], 30);
    step();
    @(negedge CLK);
    check("drain_shift1", col_chain[NCol], 20);
    step();
    @(negedge CLK);
    check("drain_shift2", col_chain[NCol], 10);
    step();
    col_load = 1; col_shift = 1;
    col_a[0] = 11; col_a[1] = 21; col_a[2] = 31; col_v = 1; col_f = 1; col_l = 1;
    @(negedge CLK);
    check("drain_shift3", col_chain[NCol], 0);
    step();
    col_load = 0; col_shift = 0; col_v = 0; col_f = 0; col_l = 0;
    @(negedge CLK);
    check("load_wins_pre_update", col_chain[NCol], 30);
    check("col_new_result", col_res[2], 31);
    check("col_mid_chain", col_chain[2], 20);

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_pe_acc.md
Name: systolic_pe_acc

Overview:
Parametrised output-stationary processing element for the next-generation systolic matrix multiplier.
- Forwards A east and B south, each with a one-cycle register stage.
- Accumulates A*B under a valid/first/last tile protocol, so back-to-back tiles run without bubbles.
- Exposes each tile result through a per-column load/shift drain chain, so results unload while the next tile computes.

Parameters:
DATAWIDTH, 8, operand width of A and B
ACCWIDTH, 2*DATAWIDTH+4, accumulator and result width
SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned

Ports:
CLK  in  1  clock
RSTn  in  1  reset
a_in  in  DATAWIDTH  A operand from west neighbour
b_in  in  DATAWIDTH  B operand from north neighbour
in_valid  in  1  operand pair valid
in_first  in  1  first pair of a tile (qualified by in_valid)
in_last  in  1  last pair of a tile (qualified by in_valid)
a_out  out  DATAWIDTH  registered a_in, to east
b_out  out  DATAWIDTH  registered b_in, to south
valid_out / first_out / last_out  out  1 each  registered in_valid/in_first/in_last, aligned with a_out/b_out
result  out  ACCWIDTH  last completed tile sum
result_valid  out  1  one-cycle pulse when result updates
res_load  in  1  copy result into drain register
res_shift  in  1  drain register takes chain_in
chain_in  in  ACCWIDTH  drain value from north PE
chain_out  out  ACCWIDTH  drain register, to south PE
ovf  out  1  sticky overflow flag (present only with the optional feature)

Behaviour:
Reset:
- Reset is RSTn, asynchronous, active-low; clock is CLK.
- Every register and every output is 0 during reset.
- Reset mid-tile discards the partial sum; the first tile after reset must begin with in_first.

Operand forwarding:
- a_out, b_out, valid_out, first_out and last_out are registered copies of their inputs.
- Latency is 1 cycle, updated every cycle, independent of valid.

Product and accumulation:
- prod = a_in*b_in, 2*DATAWIDTH bits, sign- or zero-extended to ACCWIDTH per SIGNED.
- acc_next = (in_first ? 0 : acc) + prod. Wraps modulo 2^ACCWIDTH.
- acc <= acc_next only when in_valid. Otherwise acc holds.
- in_first and in_last are ignored when in_valid=0.
- in_first=in_last=1 forms a single-pair tile: result = prod.

Result capture:
- When in_valid && in_last: result <= acc_next, and result_valid = 1 the next cycle only.
- Latency: result appears 1 cycle after the cycle presenting the last pair.
- result holds until the next capture.
- A last pair followed immediately by the next tile's first pair is legal, with no bubble.

Drain chain:
- res_load: chain_out <= result, using the pre-update value if a capture occurs in the same cycle.
- Else res_shift: chain_out <= chain_in.
- Else chain_out holds.
- When res_load and res_shift are asserted together, load wins.

Arithmetic: no rounding. All adds are ACCWIDTH wide.

Optional Feature:
Macro: SYSTOLIC_PE_SAT_EN.
- Defined:
  - The accumulator add saturates instead of wrapping.
  - Saturation limits: unsigned [0, 2^ACCWIDTH-1]; signed [-2^(ACCWIDTH-1), 2^(ACCWIDTH-1)-1].
  - Port ovf exists. It sets when any accepted add saturates and clears only on an in_valid&&in_first cycle or on reset.
  - On an in_first cycle, ovf is set again if that same add saturates.
- Not defined: wrap-around arithmetic, and no ovf port.

Decomposition:
- Package systolic_pkg:
  - default DATAWIDTH and ACCWIDTH constants;
  - acc-width helper function (2*DW+guard);
  - signed/unsigned mode constants shared with the array top.
- Sub-module pe_mac: combinational extend+multiply+add, with the saturation logic under the macro.
- The PE holds all registers and the tile and drain control.

Test Plan:
1. Reset: assert RSTn=0 with toggling inputs -> all outputs 0. Release -> a_out follows a_in one cycle later.
2. Unsigned tile, DW=8, AW=20: (3,4)first, (5,6), (7,8)last -> result=98, result_valid high exactly one cycle, 1 cycle after the last pair.
3. Back-to-back tiles: tile 2 follows immediately with (1,1)first, (2,2)last -> result=5 two cycles after 98, no bubble; an idle invalid cycle mid-tile does not change the sum.
4. SIGNED=1: (-3,4)first, (2,-5)last -> result=-22 (0xFFFEA at AW=20).
5. Three-PE column holding 10, 20, 30 (top to bottom): res_load, then res_shift x3 with chain_in=0 at the top -> bottom chain_out 30, 20, 10, 0. Simultaneous load+shift -> load value wins.
6. (255,255) for 17 valid cycles, AW=20, first on cycle 1, last on cycle 17:
   - without macro -> result=56849;
   - with SYSTOLIC_PE_SAT_EN -> result=1048575 and ovf=1; the next in_first clears ovf.
   Also assert RSTn mid-tile -> acc, result and ovf return to 0.
